// File: rtl/mcl_horner_stage.sv
// rtl/mcl_horner_stage.sv - one Horner step (post = mult_1*mult_2 + add_1) of the fixed-point sine pipeline
// Sign-magnitude operands; elastic in-order slot chain carrying x and x^2 in lockstep with the result.
module mcl_horner_stage #(
    parameter int FXD_N               = 8,
    parameter int FXD_Q               = 4,
    parameter int NUM_CYCLES_FOR_MULT = 1,
    parameter int NUM_CYCLES_FOR_ADD  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_avail_mult_1,
    output logic             pre_get_mult_1,
    input  logic [FXD_N-1:0] pre_data_mult_1,
    input  logic             pre_avail_mult_2,
    output logic             pre_get_mult_2,
    input  logic [FXD_N-1:0] pre_data_mult_2,
    input  logic             pre_avail_add_1,
    output logic             pre_get_add_1,
    input  logic [FXD_N-1:0] pre_data_add_1,
    output logic             post_avail_mul_add,
    input  logic             post_get_mul_add,
    output logic [FXD_N-1:0] post_data_mul_add,
    input  logic             pre_avail_pl_x,
    output logic             pre_get_pl_x,
    input  logic [FXD_N-1:0] pre_data_pl_x,
    output logic             post_avail_pl_x,
    input  logic             post_get_pl_x,
    output logic [FXD_N-1:0] post_data_pl_x,
    input  logic             pre_avail_pl_x2,
    output logic             pre_get_pl_x2,
    input  logic [FXD_N-1:0] pre_data_pl_x2,
    output logic             post_avail_pl_x2,
    input  logic             post_get_pl_x2,
    output logic [FXD_N-1:0] post_data_pl_x2
);

    localparam int MS = NUM_CYCLES_FOR_MULT;
    localparam int AS = NUM_CYCLES_FOR_ADD;
    localparam int L  = MS + AS;
    localparam int MW = FXD_N - 1;
    localparam int PW = 2 * MW;
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

    function automatic logic [FXD_N-1:0] fx_mul(input logic [FXD_N-1:0] a, input logic [FXD_N-1:0] b);
        logic [PW-1:0] p;
        logic [MW-1:0] m;
        logic          s;
        p = {{MW{1'b0}}, a[MW-1:0]} * {{MW{1'b0}}, b[MW-1:0]};
        p = p >> FXD_Q;
        if (p > {{MW{1'b0}}, MAG_MAX}) m = MAG_MAX;
        else                           m = p[MW-1:0];
        s = (a[MW] ^ b[MW]) & (m != '0);
        return {s, m};
    endfunction

    function automatic logic [FXD_N-1:0] fx_add(input logic [FXD_N-1:0] a, input logic [FXD_N-1:0] b);
        logic [MW:0]   sum;
        logic [MW-1:0] m;
        logic          s;
        sum = {1'b0, a[MW-1:0]} + {1'b0, b[MW-1:0]};
        if (a[MW] == b[MW]) begin
            m = sum[MW] ? MAG_MAX : sum[MW-1:0];
            s = a[MW];
        end else if (a[MW-1:0] >= b[MW-1:0]) begin
            m = a[MW-1:0] - b[MW-1:0];
            s = a[MW];
        end else begin
            m = b[MW-1:0] - a[MW-1:0];
            s = b[MW];
        end
        s = s & (m != '0);
        return {s, m};
    endfunction

    logic [L-1:0]     valid_q, valid_d;
    logic [FXD_N-1:0] m_prod_q [MS];
    logic [FXD_N-1:0] m_prod_d [MS];
    logic [FXD_N-1:0] m_add_q  [MS];
    logic [FXD_N-1:0] m_add_d  [MS];
    logic [FXD_N-1:0] m_x_q    [MS];
    logic [FXD_N-1:0] m_x_d    [MS];
    logic [FXD_N-1:0] m_x2_q   [MS];
    logic [FXD_N-1:0] m_x2_d   [MS];
    logic [FXD_N-1:0] a_sum_q  [AS];
    logic [FXD_N-1:0] a_sum_d  [AS];
    logic [FXD_N-1:0] a_x_q    [AS];
    logic [FXD_N-1:0] a_x_d    [AS];
    logic [FXD_N-1:0] a_x2_q   [AS];
    logic [FXD_N-1:0] a_x2_d   [AS];

    logic         in_ok;
    logic         pop;
    logic         accept;
    logic [L:0]   ready;
    logic [L-1:0] adv;
    logic [L-1:0] load;

    always_comb begin
        in_ok  = pre_avail_mult_1 & pre_avail_mult_2 & pre_avail_add_1 & pre_avail_pl_x & pre_avail_pl_x2;
        pop    = valid_q[L-1] & post_get_mul_add & post_get_pl_x & post_get_pl_x2;
        ready  = '0;
        adv    = '0;
        load   = '0;
        // ready[L] stands for the downstream sink; each slot drains only into a ready successor
        ready[L] = pop;
        for (int k = L - 1; k >= 0; k--) begin
            adv[k]   = valid_q[k] & ready[k+1];
            ready[k] = ~valid_q[k] | adv[k];
        end
        accept  = in_ok & ready[0];
        load[0] = accept;
        for (int k = 1; k < L; k++) load[k] = adv[k-1];
        for (int k = 0; k < L; k++) valid_d[k] = load[k] | (valid_q[k] & ~adv[k]);

        m_prod_d = m_prod_q;
        m_add_d  = m_add_q;
        m_x_d    = m_x_q;
        m_x2_d   = m_x2_q;
        a_sum_d  = a_sum_q;
        a_x_d    = a_x_q;
        a_x2_d   = a_x2_q;

        if (load[0]) begin
            m_prod_d[0] = fx_mul(pre_data_mult_1, pre_data_mult_2);
            m_add_d[0]  = pre_data_add_1;
            m_x_d[0]    = pre_data_pl_x;
            m_x2_d[0]   = pre_data_pl_x2;
        end
        for (int k = 1; k < MS; k++) begin
            if (load[k]) begin
                m_prod_d[k] = m_prod_q[k-1];
                m_add_d[k]  = m_add_q[k-1];
                m_x_d[k]    = m_x_q[k-1];
                m_x2_d[k]   = m_x2_q[k-1];
            end
        end
        if (load[MS]) begin
            a_sum_d[0] = fx_add(m_prod_q[MS-1], m_add_q[MS-1]);
            a_x_d[0]   = m_x_q[MS-1];
            a_x2_d[0]  = m_x2_q[MS-1];
        end
        for (int j = 1; j < AS; j++) begin
            if (load[MS+j]) begin
                a_sum_d[j] = a_sum_q[j-1];
                a_x_d[j]   = a_x_q[j-1];
                a_x2_d[j]  = a_x2_q[j-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < MS; k++) begin
                m_prod_q[k] <= '0;
                m_add_q[k]  <= '0;
                m_x_q[k]    <= '0;
                m_x2_q[k]   <= '0;
            end
            for (int j = 0; j < AS; j++) begin
                a_sum_q[j] <= '0;
                a_x_q[j]   <= '0;
                a_x2_q[j]  <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            m_prod_q <= m_prod_d;
            m_add_q  <= m_add_d;
            m_x_q    <= m_x_d;
            m_x2_q   <= m_x2_d;
            a_sum_q  <= a_sum_d;
            a_x_q    <= a_x_d;
            a_x2_q   <= a_x2_d;
        end
    end

    assign pre_get_mult_1     = accept;
    assign pre_get_mult_2     = accept;
    assign pre_get_add_1      = accept;
    assign pre_get_pl_x       = accept;
    assign pre_get_pl_x2      = accept;
    assign post_avail_mul_add = valid_q[L-1];
    assign post_avail_pl_x    = valid_q[L-1];
    assign post_avail_pl_x2   = valid_q[L-1];
    assign post_data_mul_add  = a_sum_q[AS-1];
    assign post_data_pl_x     = a_x_q[AS-1];
    assign post_data_pl_x2    = a_x2_q[AS-1];

endmodule

// File: tb/tb_mcl_horner_stage.sv
// tb/tb_mcl_horner_stage.sv - directed vector bench for mcl_horner_stage (N=8, Q=4, latency 2)
module tb_mcl_horner_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_avail_mult_1, pre_avail_mult_2, pre_avail_add_1, pre_avail_pl_x, pre_avail_pl_x2;
    logic       pre_get_mult_1, pre_get_mult_2, pre_get_add_1, pre_get_pl_x, pre_get_pl_x2;
    logic [7:0] pre_data_mult_1, pre_data_mult_2, pre_data_add_1, pre_data_pl_x, pre_data_pl_x2;
    logic       post_avail_mul_add, post_avail_pl_x, post_avail_pl_x2;
    logic       post_get_mul_add, post_get_pl_x, post_get_pl_x2;
    logic [7:0] post_data_mul_add, post_data_pl_x, post_data_pl_x2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a, b, add, x, x2, res;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    mcl_horner_stage dut (
        .clk(clk), .rst_n(rst_n),
        .pre_avail_mult_1(pre_avail_mult_1), .pre_get_mult_1(pre_get_mult_1), .pre_data_mult_1(pre_data_mult_1),
        .pre_avail_mult_2(pre_avail_mult_2), .pre_get_mult_2(pre_get_mult_2), .pre_data_mult_2(pre_data_mult_2),
        .pre_avail_add_1(pre_avail_add_1), .pre_get_add_1(pre_get_add_1), .pre_data_add_1(pre_data_add_1),
        .post_avail_mul_add(post_avail_mul_add), .post_get_mul_add(post_get_mul_add),
        .post_data_mul_add(post_data_mul_add),
        .pre_avail_pl_x(pre_avail_pl_x), .pre_get_pl_x(pre_get_pl_x), .pre_data_pl_x(pre_data_pl_x),
        .post_avail_pl_x(post_avail_pl_x), .post_get_pl_x(post_get_pl_x), .post_data_pl_x(post_data_pl_x),
        .pre_avail_pl_x2(pre_avail_pl_x2), .pre_get_pl_x2(pre_get_pl_x2), .pre_data_pl_x2(pre_data_pl_x2),
        .post_avail_pl_x2(post_avail_pl_x2), .post_get_pl_x2(post_get_pl_x2), .post_data_pl_x2(post_data_pl_x2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic av);
        pre_data_mult_1 = v.a;
        pre_data_mult_2 = v.b;
        pre_data_add_1  = v.add;
        pre_data_pl_x   = v.x;
        pre_data_pl_x2  = v.x2;
        pre_avail_mult_1 = av;
        pre_avail_mult_2 = av;
        pre_avail_add_1  = av;
        pre_avail_pl_x   = av;
        pre_avail_pl_x2  = av;
    endtask

    task automatic set_get(input logic gm, input logic gx, input logic gx2);
        post_get_mul_add = gm;
        post_get_pl_x    = gx;
        post_get_pl_x2   = gx2;
    endtask

    task automatic chk_gets(input string name, input logic exp);
        chk(name, {27'd0, pre_get_mult_1, pre_get_mult_2, pre_get_add_1, pre_get_pl_x, pre_get_pl_x2},
            exp ? 32'h1f : 32'h0);
    endtask

    task automatic chk_out(input string name, input vec_t v);
        chk({name, "_avail"}, {29'd0, post_avail_mul_add, post_avail_pl_x, post_avail_pl_x2}, 32'h7);
        chk({name, "_res"}, {24'd0, post_data_mul_add}, {24'd0, v.res});
        chk({name, "_x"},   {24'd0, post_data_pl_x},    {24'd0, v.x});
        chk({name, "_x2"},  {24'd0, post_data_pl_x2},   {24'd0, v.x2});
    endtask

    task automatic chk_empty(input string name);
        chk(name, {29'd0, post_avail_mul_add, post_avail_pl_x, post_avail_pl_x2}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{a: 8'h18, b: 8'h20, add: 8'h88, x: 8'h11, x2: 8'h22, res: 8'h28};
        vecs[1] = '{a: 8'h70, b: 8'h20, add: 8'h00, x: 8'h33, x2: 8'h44, res: 8'h7F};
        vecs[2] = '{a: 8'h90, b: 8'h10, add: 8'h10, x: 8'h55, x2: 8'h66, res: 8'h00};
        vecs[3] = '{a: 8'hF0, b: 8'h20, add: 8'h90, x: 8'h77, x2: 8'h88, res: 8'hFF};
        vecs[4] = '{a: 8'h10, b: 8'h10, add: 8'hB0, x: 8'h99, x2: 8'hAA, res: 8'hA0};
        vecs[5] = '{a: 8'h01, b: 8'h0F, add: 8'h05, x: 8'hBB, x2: 8'hCC, res: 8'h05};
        vecs[6] = '{a: 8'h24, b: 8'h14, add: 8'h13, x: 8'hDD, x2: 8'hEE, res: 8'h40};
        vecs[7] = '{a: 8'hA0, b: 8'h98, add: 8'h08, x: 8'h01, x2: 8'h02, res: 8'h38};

        rst_n = 1'b0;
        drive(vecs[0], 1'b0);
        set_get(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk_empty("reset_avail");
        chk("reset_data", {8'd0, post_data_mul_add, post_data_pl_x, post_data_pl_x2}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk_gets("idle_no_get", 1'b0);

        // Any single avail low blocks acceptance
        @(negedge clk);
        drive(vecs[0], 1'b1);
        pre_avail_add_1 = 1'b0;
        #1 chk_gets("avail_add_low", 1'b0);
        pre_avail_add_1 = 1'b1;
        pre_avail_pl_x2 = 1'b0;
        #1 chk_gets("avail_x2_low", 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_empty("no_accept_empty");

        // Table: isolated items, latency 2
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i], 1'b1);
            #1 chk_gets($sformatf("v%0d_get", i), 1'b1);
            @(posedge clk);
            @(negedge clk);
            drive(vecs[i], 1'b0);
            chk_empty($sformatf("v%0d_lat1", i));
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("v%0d", i), vecs[i]);
        end
        @(posedge clk);
        @(negedge clk);
        chk_empty("table_drained");

        // Backpressure: two accepted, third stalled, partial get does not pop
        set_get(1'b0, 1'b0, 1'b0);
        drive(vecs[0], 1'b1);
        #1 chk_gets("bp_get0", 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[6], 1'b1);
        #1 chk_gets("bp_get1", 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[7], 1'b1);
        #1 chk_gets("bp_full_get", 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_out("bp_hold", vecs[0]);
        set_get(1'b1, 1'b0, 1'b1);
        #1 chk_gets("bp_partial_get", 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_out("bp_partial_hold", vecs[0]);
        set_get(1'b1, 1'b1, 1'b1);
        #1 chk_gets("bp_pop_accept", 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[7], 1'b0);
        chk_out("bp_out1", vecs[6]);
        @(posedge clk);
        @(negedge clk);
        chk_out("bp_out2", vecs[7]);
        @(posedge clk);
        @(negedge clk);
        chk_empty("bp_drained");

        // Streaming: one result per clock
        for (int c = 0; c < 7; c++) begin
            if (c >= 2 && c < 6) chk_out($sformatf("st%0d", c - 2), vecs[c - 1]);
            if (c == 6) chk_empty("st_drained");
            if (c < 4) begin
                drive(vecs[c + 1], 1'b1);
                #1 chk_gets($sformatf("st_get%0d", c), 1'b1);
            end else begin
                drive(vecs[0], 1'b0);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Reset with the pipe full
        set_get(1'b0, 1'b0, 1'b0);
        drive(vecs[3], 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(vecs[3], 1'b0);
        chk_out("rst_pre", vecs[3]);
        #2 rst_n = 1'b0;
        #1 chk_empty("rst_async_avail");
        chk("rst_async_data", {8'd0, post_data_mul_add, post_data_pl_x, post_data_pl_x2}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_get(1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_empty("rst_no_stale");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
